// File: rtl/frame_demux_pkg.sv
// Shared types, default sizing and width helpers for the frame demultiplexer.
package frame_demux_pkg;

    localparam int DEF_DW          = 8;
    localparam int DEF_FAST_WORDS  = 16;
    localparam int DEF_SLOW_WORDS  = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_GAP_TIMEOUT = 1024;
    localparam int DEF_FCW         = 8;

    // Index/counter width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FRAME_WORDS = DEF_FAST_WORDS + DEF_SLOW_WORDS;
    localparam int CW          = idx_w(FRAME_WORDS);
    localparam int TW          = idx_w(DEF_GAP_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FAST,
        ST_SLOW
    } state_t;

endpackage

// File: rtl/frame_demux_if.sv
// Word input and fast/slow channel outputs of the frame demultiplexer.
interface frame_demux_if
    import frame_demux_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int FIW = idx_w(DEF_FAST_WORDS),
    parameter int SIW = idx_w(DEF_SLOW_WORDS),
    parameter int FCW = DEF_FCW
) ();

    logic [DW-1:0]  iData;
    logic           strob;
    logic [DW-1:0]  fData;
    logic [FIW-1:0] fIdx;
    logic           fVal;
    logic [DW-1:0]  sData;
    logic [SIW-1:0] sIdx;
    logic           sVal;
    logic           frameDone;
    logic           frameErr;
    logic [FCW-1:0] frameCnt;

    modport master (
        output iData, strob,
        input  fData, fIdx, fVal, sData, sIdx, sVal, frameDone, frameErr, frameCnt
    );

    modport slave (
        input  iData, strob,
        output fData, fIdx, fVal, sData, sIdx, sVal, frameDone, frameErr, frameCnt
    );

endinterface

// File: rtl/frame_demux_strobe_edge_sync.sv
// Synchronises an asynchronous strobe into clk and emits a one-cycle rising-edge pulse.
module strobe_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strob,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], strob};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/frame_demux.sv
// Splits a strobed word stream into fixed-size frames: leading words to the fast
// channel, trailing words to the slow channel, with gap-timeout resynchronisation.
module frame_demux
    import frame_demux_pkg::*;
#(
    parameter int DW          = DEF_DW,
    parameter int FAST_WORDS  = DEF_FAST_WORDS,
    parameter int SLOW_WORDS  = DEF_SLOW_WORDS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT,
    parameter int FCW         = DEF_FCW
) (
    input  logic          clk,
    input  logic          rst,
    frame_demux_if.slave  bus
);

    localparam int FRAME_W = FAST_WORDS + SLOW_WORDS;
    localparam int CNT_W   = idx_w(FRAME_W);
    localparam int TMR_W   = idx_w(GAP_TIMEOUT);
    localparam int FIW     = idx_w(FAST_WORDS);
    localparam int SIW     = idx_w(SLOW_WORDS);

    localparam logic [CNT_W-1:0] FAST_C = CNT_W'(FAST_WORDS);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_W - 1);
    localparam logic [TMR_W-1:0] TMAX_C = TMR_W'(GAP_TIMEOUT - 1);

    logic w_edge;

    strobe_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .clk    (clk),
        .rst    (rst),
        .strob  (bus.strob),
        .o_edge (w_edge)
    );

    state_t           r_state,  w_state_next;
    logic [CNT_W-1:0] r_cnt,    w_cnt_next;
    logic [TMR_W-1:0] r_timer,  w_timer_next;
    logic [DW-1:0]    r_fdata,  w_fdata_next;
    logic [FIW-1:0]   r_fidx,   w_fidx_next;
    logic             r_fval,   w_fval_next;
    logic [DW-1:0]    r_sdata,  w_sdata_next;
    logic [SIW-1:0]   r_sidx,   w_sidx_next;
    logic             r_sval,   w_sval_next;
    logic             r_done,   w_done_next;
    logic             r_err,    w_err_next;
    logic [FCW-1:0]   r_fcnt,   w_fcnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_timer <= '0;
            r_fdata <= '0;
            r_fidx  <= '0;
            r_fval  <= 1'b0;
            r_sdata <= '0;
            r_sidx  <= '0;
            r_sval  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_timer <= w_timer_next;
            r_fdata <= w_fdata_next;
            r_fidx  <= w_fidx_next;
            r_fval  <= w_fval_next;
            r_sdata <= w_sdata_next;
            r_sidx  <= w_sidx_next;
            r_sval  <= w_sval_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_timer_next = r_timer;
        w_fdata_next = r_fdata;
        w_fidx_next  = r_fidx;
        w_fval_next  = 1'b0;
        w_sdata_next = r_sdata;
        w_sidx_next  = r_sidx;
        w_sval_next  = 1'b0;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_fcnt_next  = r_fcnt;

        // An edge takes priority over a timeout expiring in the same cycle.
        if (w_edge) begin
            w_timer_next = '0;
            if (r_state != ST_SLOW) begin
                w_fdata_next = bus.iData;
                w_fidx_next  = FIW'(r_cnt);
                w_fval_next  = 1'b1;
            end else begin
                w_sdata_next = bus.iData;
                w_sidx_next  = SIW'(r_cnt - FAST_C);
                w_sval_next  = 1'b1;
            end
            if (r_cnt == LAST_C) begin
                w_cnt_next  = '0;
                w_done_next = 1'b1;
                w_fcnt_next = r_fcnt + FCW'(1);
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end else if (r_state == ST_IDLE) begin
            w_timer_next = '0;
        end else if (r_timer == TMAX_C) begin
            w_cnt_next   = '0;
            w_timer_next = '0;
            w_err_next   = 1'b1;
        end else begin
            w_timer_next = r_timer + TMR_W'(1);
        end

        if (w_cnt_next == '0)
            w_state_next = ST_IDLE;
        else if (w_cnt_next < FAST_C)
            w_state_next = ST_FAST;
        else
            w_state_next = ST_SLOW;
    end

    assign bus.fData     = r_fdata;
    assign bus.fIdx      = r_fidx;
    assign bus.fVal      = r_fval;
    assign bus.sData     = r_sdata;
    assign bus.sIdx      = r_sidx;
    assign bus.sVal      = r_sval;
    assign bus.frameDone = r_done;
    assign bus.frameErr  = r_err;
    assign bus.frameCnt  = r_fcnt;

endmodule

// File: tb/tb_frame_demux.sv
// Directed checks of frame_demux: default build plus a 12-bit, 1+3 word, 3-stage build.
module tb_frame_demux;
    import frame_demux_pkg::*;

    localparam int G      = 1024;
    localparam int B_DW   = 12;
    localparam int B_FAST = 1;
    localparam int B_SLOW = 3;
    localparam int B_SYNC = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_demux_if #(.DW(8), .FIW(idx_w(16)), .SIW(idx_w(2)), .FCW(8)) bus_a ();
    frame_demux_if #(.DW(B_DW), .FIW(idx_w(B_FAST)), .SIW(idx_w(B_SLOW)), .FCW(8)) bus_b ();

    frame_demux u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    frame_demux #(
        .DW          (B_DW),
        .FAST_WORDS  (B_FAST),
        .SLOW_WORDS  (B_SLOW),
        .SYNC_STAGES (B_SYNC)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int fa_data[$], fa_idx[$], fa_cyc[$], sa_data[$], sa_idx[$], sa_cyc[$], a_drv[$];
    int fb_data[$], fb_idx[$], fb_cyc[$], sb_data[$], sb_idx[$], sb_cyc[$], b_drv[$];
    int a_done = 0, a_done_alone = 0, a_done_cyc = 0, a_err = 0, a_err_cyc = 0;
    int b_done = 0, b_done_cyc = 0, b_err = 0;

    always @(negedge clk) begin
        if (bus_a.fVal) begin
            fa_data.push_back(int'(bus_a.fData)); fa_idx.push_back(int'(bus_a.fIdx)); fa_cyc.push_back(cyc);
        end
        if (bus_a.sVal) begin
            sa_data.push_back(int'(bus_a.sData)); sa_idx.push_back(int'(bus_a.sIdx)); sa_cyc.push_back(cyc);
        end
        if (bus_a.frameDone) begin
            a_done++; a_done_cyc = cyc;
            if (!bus_a.sVal) a_done_alone++;
        end
        if (bus_a.frameErr) begin
            a_err++; a_err_cyc = cyc;
        end
        if (bus_b.fVal) begin
            fb_data.push_back(int'(bus_b.fData)); fb_idx.push_back(int'(bus_b.fIdx)); fb_cyc.push_back(cyc);
        end
        if (bus_b.sVal) begin
            sb_data.push_back(int'(bus_b.sData)); sb_idx.push_back(int'(bus_b.sIdx)); sb_cyc.push_back(cyc);
        end
        if (bus_b.frameDone) begin
            b_done++; b_done_cyc = cyc;
        end
        if (bus_b.frameErr) b_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        fa_data.delete(); fa_idx.delete(); fa_cyc.delete();
        sa_data.delete(); sa_idx.delete(); sa_cyc.delete(); a_drv.delete();
        a_done = 0; a_done_alone = 0; a_err = 0;
    endtask

    // Entered #1 after a posedge; strobe high for 3 cycles, low for 'low' cycles.
    task automatic send_a(input logic [7:0] d, input int low);
        a_drv.push_back(cyc);
        bus_a.iData = d;
        bus_a.strob = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_a.strob = 1'b0;
        repeat (low) @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [11:0] d, input int low);
        b_drv.push_back(cyc);
        bus_b.iData = d;
        bus_b.strob = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_b.strob = 1'b0;
        repeat (low) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] bv [4];
        int t0;
        bv = '{12'hABC, 12'h123, 12'h456, 12'h789};
        bus_a.iData = '0; bus_a.strob = 1'b0;
        bus_b.iData = '0; bus_b.strob = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_fData", 32'(bus_a.fData), 0);
        chk("rst_fIdx", 32'(bus_a.fIdx), 0);
        chk("rst_pulses", 32'({bus_a.fVal, bus_a.sVal, bus_a.frameDone, bus_a.frameErr}), 0);
        chk("rst_sData_sIdx", 32'({bus_a.sData, bus_a.sIdx}), 0);
        chk("rst_frameCnt", 32'(bus_a.frameCnt), 0);
        chk("rst_b_outs", 32'({bus_b.fData, bus_b.sData, bus_b.frameCnt}), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // One full frame of 18 words, 8 clk apart
        clear_a();
        for (int i = 0; i < FRAME_WORDS; i++) send_a(8'(i), 5);
        repeat (10) @(posedge clk);
        #1;
        chk("t1_fast_count", 32'(fa_data.size()), 16);
        for (int i = 0; i < fa_data.size() && i < 16; i++) begin
            chk($sformatf("t1_fData%0d", i), 32'(fa_data[i]), 32'(i));
            chk($sformatf("t1_fIdx%0d", i), 32'(fa_idx[i]), 32'(i));
        end
        if (fa_cyc.size() > 0) chk("t1_latency", 32'(fa_cyc[0] - a_drv[0]), 3);
        chk("t1_slow_count", 32'(sa_data.size()), 2);
        if (sa_data.size() == 2) begin
            chk("t1_sIdx0", 32'(sa_idx[0]), 0);
            chk("t1_sData0", 32'(sa_data[0]), 'h10);
            chk("t1_sIdx1", 32'(sa_idx[1]), 1);
            chk("t1_sData1", 32'(sa_data[1]), 'h11);
            chk("t1_done_with_last_sval", 32'(a_done_cyc), 32'(sa_cyc[1]));
        end
        chk("t1_done_count", 32'(a_done), 1);
        chk("t1_done_alone", 32'(a_done_alone), 0);
        chk("t1_frameCnt", 32'(bus_a.frameCnt), 1);
        chk("t1_no_err", 32'(a_err), 0);

        // 256 back-to-back frames: counter wraps
        do_reset();
        clear_a();
        for (int f = 0; f < 256; f++) begin
            for (int w = 0; w < FRAME_WORDS; w++) send_a(8'(w), 3);
            if (f == 254) begin
                @(negedge clk);
                chk("t2_frameCnt_255", 32'(bus_a.frameCnt), 255);
                @(posedge clk);
                #1;
            end
        end
        repeat (5) @(posedge clk);
        #1;
        chk("t2_frameCnt_wrap", 32'(bus_a.frameCnt), 0);
        chk("t2_done_count", 32'(a_done), 256);
        chk("t2_done_alone", 32'(a_done_alone), 0);
        chk("t2_no_err", 32'(a_err), 0);

        // Gap timeout after 5 words
        do_reset();
        clear_a();
        for (int i = 0; i < 5; i++) send_a(8'('hA0 + i), 5);
        repeat (2000) @(posedge clk);
        #1;
        chk("t3_err_count", 32'(a_err), 1);
        chk("t3_fast_count", 32'(fa_cyc.size()), 5);
        if (fa_cyc.size() == 5) chk("t3_err_delay", 32'(a_err_cyc - fa_cyc[4]), G);
        chk("t3_frameCnt", 32'(bus_a.frameCnt), 0);
        clear_a();
        send_a(8'h55, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_resync_count", 32'(fa_idx.size()), 1);
        if (fa_idx.size() > 0) begin
            chk("t3_resync_fIdx", 32'(fa_idx[0]), 0);
            chk("t3_resync_fData", 32'(fa_data[0]), 'h55);
        end

        // Edge arriving on the timer's last cycle wins over the timeout
        clear_a();
        for (int i = 1; i < 5; i++) send_a(8'('hB0 + i), 5);
        t0 = (fa_cyc.size() > 0) ? fa_cyc[$] : cyc;
        while (cyc < t0 + G - 3) begin
            @(posedge clk);
            #1;
        end
        send_a(8'hC5, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_word_count", 32'(fa_idx.size()), 5);
        if (fa_idx.size() == 5) begin
            chk("t4_fIdx", 32'(fa_idx[4]), 5);
            chk("t4_fData", 32'(fa_data[4]), 'hC5);
            chk("t4_edge_at_limit", 32'(fa_cyc[4] - t0), G);
        end
        chk("t4_no_err", 32'(a_err), 0);

        // Asynchronous reset mid-frame after 10 words
        do_reset();
        clear_a();
        for (int i = 0; i < 10; i++) send_a(8'('h60 + i), 4);
        chk("t5_pre_rst_fData", 32'(bus_a.fData), 'h69);
        chk("t5_pre_rst_fIdx", 32'(bus_a.fIdx), 9);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_async_rst", 32'({bus_a.fData, bus_a.fIdx, bus_a.sData, bus_a.sIdx, bus_a.frameCnt}), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        clear_a();
        send_a(8'h77, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_after_rst_count", 32'(fa_idx.size()), 1);
        if (fa_idx.size() > 0) begin
            chk("t5_after_rst_fIdx", 32'(fa_idx[0]), 0);
            chk("t5_after_rst_fData", 32'(fa_data[0]), 'h77);
        end
        chk("t5_no_err", 32'(a_err), 0);

        // 12-bit build, one fast word and three slow words
        for (int i = 0; i < 4; i++) send_b(bv[i], 5);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_fast_count", 32'(fb_data.size()), 1);
        if (fb_data.size() == 1) begin
            chk("t6_fData", 32'(fb_data[0]), 'hABC);
            chk("t6_fIdx", 32'(fb_idx[0]), 0);
            chk("t6_f_latency", 32'(fb_cyc[0] - b_drv[0]), 4);
        end
        chk("t6_slow_count", 32'(sb_data.size()), 3);
        for (int i = 0; i < sb_data.size() && i < 3; i++) begin
            chk($sformatf("t6_sIdx%0d", i), 32'(sb_idx[i]), 32'(i));
            chk($sformatf("t6_sData%0d", i), 32'(sb_data[i]), 32'(bv[i + 1]));
            chk($sformatf("t6_s_latency%0d", i), 32'(sb_cyc[i] - b_drv[i + 1]), 4);
        end
        chk("t6_done_count", 32'(b_done), 1);
        if (sb_cyc.size() == 3) chk("t6_done_on_4th", 32'(b_done_cyc), 32'(sb_cyc[2]));
        chk("t6_frameCnt", 32'(bus_b.frameCnt), 1);
        chk("t6_no_err", 32'(b_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_demux.md
Name: frame_demux

Overview:
- Parametrised successor to the fixed 16+2 byte writer. It receives a byte-serial frame on an asynchronous strobe and splits each frame into a fast field (FAST_WORDS words) and a slow field (SLOW_WORDS words).
- Adds configurable data width, configurable synchroniser depth, per-word index outputs, an end-of-frame pulse, a frame counter, and inter-word gap-timeout resynchronisation with an error pulse.
- Sits between the serial receive front end and the fast/slow telemetry buffers.

Parameters:
- DW, 8: data word width in bits.
- FAST_WORDS, 16: words per frame routed to the fast channel; must be >= 1.
- SLOW_WORDS, 2: words per frame routed to the slow channel; must be >= 1.
- SYNC_STAGES, 2: strobe synchroniser flops; must be >= 2.
- GAP_TIMEOUT, 1024: clk cycles without a strobe edge, mid-frame, before the frame is aborted; must be >= 4.
- FCW, 8: frame counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- iData  in  DW  word to capture; stable from the strobe rising edge until at least SYNC_STAGES+2 clk cycles later.
- strob  in  1  asynchronous word strobe; a rising edge marks one word.
- fData  out  DW  last fast-channel word; held between captures.
- fIdx  out  clog2(FAST_WORDS)  position of fData within the fast field.
- fVal  out  1  one-cycle pulse when fData/fIdx update.
- sData  out  DW  last slow-channel word; held between captures.
- sIdx  out  clog2(SLOW_WORDS), min 1  position of sData within the slow field.
- sVal  out  1  one-cycle pulse when sData/sIdx update.
- frameDone  out  1  one-cycle pulse, coincident with the sVal of the last slow word.
- frameErr  out  1  one-cycle pulse on gap-timeout abort.
- frameCnt  out  FCW  completed-frame count; wraps.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; synchroniser, word counter (cnt) and gap timer cleared.
- Strobe sync: strob passes through SYNC_STAGES flops, then one history flop.
  - edge = sync_out & ~history.
  - Latency from the strob rising edge to the valid pulse is SYNC_STAGES+1 to SYNC_STAGES+2 clk cycles.
- On an edge cycle, iData is sampled and cnt (range 0..FAST_WORDS+SLOW_WORDS-1) advances:
  - If cnt < FAST_WORDS: fData<=iData, fIdx<=cnt, fVal<=1.
  - Otherwise: sData<=iData, sIdx<=cnt-FAST_WORDS, sVal<=1.
  - If cnt == FAST_WORDS+SLOW_WORDS-1: cnt<=0, frameDone<=1, frameCnt<=frameCnt+1 (wraps from 2^FCW-1 to 0).
  - Otherwise: cnt<=cnt+1.
- fVal, sVal, frameDone and frameErr are registered and high for exactly one cycle. They are never high on consecutive cycles, because successive edges are at least 2 cycles apart.
- Data and index outputs hold their last value; they are never zeroed except by reset.
- Gap timer:
  - Cleared on every edge and whenever cnt == 0.
  - Increments while cnt != 0 and there is no edge.
  - On reaching GAP_TIMEOUT-1: cnt<=0, timer<=0, frameErr<=1.
  - fData/sData/frameCnt are unchanged by an abort.
- Simultaneous edge and timeout expiry: the edge wins. The word is processed normally, no frameErr, and the timer is cleared.
- A strobe held high produces a single edge. A glitch shorter than one clk may be missed; that is acceptable.
- Reset asserted mid-frame: immediate return to the reset state, with no frameErr.
- FSM view of cnt:
  - IDLE (cnt=0, timer frozen).
  - FAST (0 < cnt < FAST_WORDS).
  - SLOW (cnt >= FAST_WORDS).
  - Transitions: IDLE->FAST on the first edge. The frame-end edge from SLOW returns to IDLE. A timeout from FAST or SLOW returns to IDLE.
  - If FAST_WORDS=1, the first edge from IDLE goes straight to SLOW.

Decomposition:
- Package frame_demux_pkg holds:
  - FRAME_WORDS = FAST_WORDS+SLOW_WORDS.
  - Counter width localparams CW = clog2(FRAME_WORDS) and TW = clog2(GAP_TIMEOUT).
  - A function returning max(1, clog2(n)) for index widths.
- One sub-module, strobe_edge_sync (params SYNC_STAGES; ports clk, rst, strob, edge). It is reused by the other serial receivers.

Test Plan:
- Reset with defaults, then 18 strobes carrying iData=0x00..0x11, 8 clk apart:
  - 16 fVal pulses with fIdx 0..15, fData equal to the sent word.
  - sVal with sIdx 0, sData=0x10; then sVal with sIdx 1, sData=0x11.
  - frameDone coincides with the second sVal; frameCnt=1.
- Back-to-back frames, 256 frames: frameCnt wraps to 0 after 255. The frameDone count equals 256, with no frameErr.
- Send 5 strobes, then hold strob low for 2000 clk:
  - frameErr pulses once, exactly GAP_TIMEOUT clk after the 5th edge.
  - The next strobe produces fVal with fIdx=0.
- Strobe edge detected on the exact cycle the timer hits GAP_TIMEOUT-1: no frameErr, and fIdx continues (e.g. 5).
- Assert rst mid-frame after 10 words:
  - All outputs return to 0 immediately.
  - The next word lands at fIdx=0; no frameErr.
- Params DW=12, FAST_WORDS=1, SLOW_WORDS=3, SYNC_STAGES=3, with iData 0xABC,0x123,0x456,0x789:
  - fData=0xABC.
  - sIdx 0,1,2 carry the remaining words.
  - frameDone is on the 4th word.
  - Each valid pulse arrives 4-5 clk after its strob rising edge.
